// File: rtl/tage_lookup_sequencer.sv
// Sequences TAGE index/tag generation and tagged bank accesses for one lookup and one
// update requester; owns the architectural global history register.
module tage_lookup_sequencer #(
  parameter int unsigned GlobLen      = 131,
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned BANK_LAT     = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    lk_valid,
  input  logic [ADDRESS_SIZE-1:0] lk_pc,
  output logic                    lk_ready,
  output logic                    lk_done,
  input  logic                    upd_valid,
  input  logic [ADDRESS_SIZE-1:0] upd_pc,
  input  logic                    upd_taken,
  input  logic                    upd_mispred,
  output logic                    upd_ready,
  output logic [ADDRESS_SIZE-1:0] gen_pc_addr,
  output logic [GlobLen-1:0]      gen_ghist,
  output logic                    index_tag_enable,
  output logic                    bank_rd_en,
  output logic                    bank_wr_en,
  output logic [CNT_W-1:0]        lookup_cnt,
  output logic [CNT_W-1:0]        mispred_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_RD, S_WAIT, S_DONE, S_UGEN, S_UWR
  } state_t;

  // WAIT is entered only when BANK_LAT > 1 and lasts BANK_LAT-1 cycles (count down to 0)
  localparam logic [2:0] WAIT_INIT = (BANK_LAT > 1) ? 3'(BANK_LAT - 2) : 3'd0;

  state_t                  state_q, state_d;
  logic [2:0]              wait_q;
  logic [ADDRESS_SIZE-1:0] pc_q;
  logic                    tk_q;
  logic [GlobLen-1:0]      ghist_q;
  logic [CNT_W-1:0]        lookup_cnt_q, mispred_cnt_q;
  logic                    upd_acc, lk_acc;

  assign gen_pc_addr = pc_q;
  assign gen_ghist   = ghist_q;
  assign lookup_cnt  = lookup_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  always_comb begin
    state_d          = state_q;
    lk_ready         = 1'b0;
    upd_ready        = 1'b0;
    lk_done          = 1'b0;
    index_tag_enable = 1'b0;
    bank_rd_en       = 1'b0;
    bank_wr_en       = 1'b0;
    upd_acc          = 1'b0;
    lk_acc           = 1'b0;
    case (state_q)
      S_IDLE: begin
        // readies are qualified by reset so every output reads 0 while held in reset
        upd_ready = reset;
        lk_ready  = reset & ~upd_valid;
        upd_acc   = upd_valid & upd_ready;
        lk_acc    = lk_valid & lk_ready;
        if (upd_acc)     state_d = S_UGEN;
        else if (lk_acc) state_d = S_GEN;
      end
      S_GEN: begin
        index_tag_enable = 1'b1;
        state_d          = S_RD;
      end
      S_RD: begin
        bank_rd_en = 1'b1;
        state_d    = (BANK_LAT == 1) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 3'd0) state_d = S_DONE;
      end
      S_DONE: begin
        lk_done = 1'b1;
        state_d = S_IDLE;
      end
      S_UGEN: begin
        index_tag_enable = 1'b1;
        state_d          = S_UWR;
      end
      S_UWR: begin
        bank_wr_en = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      pc_q          <= '0;
      tk_q          <= 1'b0;
      ghist_q       <= '0;
      lookup_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (upd_acc) begin
        pc_q <= upd_pc;
        tk_q <= upd_taken;
        if (upd_mispred && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end else if (lk_acc) begin
        pc_q <= lk_pc;
        if (lookup_cnt_q != '1) lookup_cnt_q <= lookup_cnt_q + CNT_W'(1);
      end
      if (state_q == S_RD)
        wait_q <= WAIT_INIT;
      else if ((state_q == S_WAIT) && (wait_q != 3'd0))
        wait_q <= wait_q - 3'd1;
      if (state_q == S_UWR)
        ghist_q <= {ghist_q[GlobLen-2:0], tk_q};
    end
  end

endmodule

// File: tb/tb_tage_lookup_sequencer.sv
// Randomized bench for tage_lookup_sequencer: two instances (BANK_LAT 1 / 4) against a
// timeline model of each operation (start cycle + fixed length per operation kind).
module tb_tage_lookup_sequencer;

  localparam int unsigned GL = 131;

  logic        CLK;
  logic        reset;
  logic        lk_valid[2], upd_valid[2], upd_taken[2], upd_mispred[2];
  logic [31:0] lk_pc[2], upd_pc[2];
  logic        lk_ready_o[2], lk_done_o[2], upd_ready_o[2], ite_o[2], rd_o[2], wr_o[2];
  logic [31:0] gpc_o[2];
  logic [GL-1:0] gh_o[2];
  logic [3:0]  lkc0, mpc0;
  logic [15:0] lkc1, mpc1;

  tage_lookup_sequencer #(.GlobLen(GL), .ADDRESS_SIZE(32), .BANK_LAT(1), .CNT_W(4)) u0 (
    .CLK(CLK), .reset(reset),
    .lk_valid(lk_valid[0]), .lk_pc(lk_pc[0]), .lk_ready(lk_ready_o[0]), .lk_done(lk_done_o[0]),
    .upd_valid(upd_valid[0]), .upd_pc(upd_pc[0]), .upd_taken(upd_taken[0]),
    .upd_mispred(upd_mispred[0]), .upd_ready(upd_ready_o[0]),
    .gen_pc_addr(gpc_o[0]), .gen_ghist(gh_o[0]), .index_tag_enable(ite_o[0]),
    .bank_rd_en(rd_o[0]), .bank_wr_en(wr_o[0]), .lookup_cnt(lkc0), .mispred_cnt(mpc0));

  tage_lookup_sequencer #(.GlobLen(GL), .ADDRESS_SIZE(32), .BANK_LAT(4), .CNT_W(16)) u1 (
    .CLK(CLK), .reset(reset),
    .lk_valid(lk_valid[1]), .lk_pc(lk_pc[1]), .lk_ready(lk_ready_o[1]), .lk_done(lk_done_o[1]),
    .upd_valid(upd_valid[1]), .upd_pc(upd_pc[1]), .upd_taken(upd_taken[1]),
    .upd_mispred(upd_mispred[1]), .upd_ready(upd_ready_o[1]),
    .gen_pc_addr(gpc_o[1]), .gen_ghist(gh_o[1]), .index_tag_enable(ite_o[1]),
    .bank_rd_en(rd_o[1]), .bank_wr_en(wr_o[1]), .lookup_cnt(lkc1), .mispred_cnt(mpc1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model: kind 0 none, 1 lookup, 2 update; op occupies cycles s .. s+len-1
  int unsigned lat_m[2]  = '{1, 4};
  int unsigned cmax_m[2] = '{15, 65535};
  int          kind_m[2], s_m[2], len_m[2];
  logic [31:0] pc_m[2];
  logic        tk_m[2];
  logic [GL-1:0] gh_m[2];
  int unsigned lkc_m[2], mpc_m[2];
  bit          lk_acc[2], upd_acc[2];
  int          cyc;
  int          total, bad;

  task automatic check_val(string tag, logic [159:0] got, logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      kind_m[i] = 0; s_m[i] = 0; len_m[i] = 0; pc_m[i] = '0; tk_m[i] = 1'b0;
      gh_m[i] = '0; lkc_m[i] = 0; mpc_m[i] = 0; lk_acc[i] = 0; upd_acc[i] = 0;
    end
  endtask

  function automatic bit busy_m(int i);
    return (kind_m[i] != 0) && (cyc < s_m[i] + len_m[i]);
  endfunction

  task automatic check_outputs(int i);
    bit busy = busy_m(i);
    int off  = cyc - s_m[i];
    string p = $sformatf("u%0d.", i);
    check_val({p, "upd_ready"}, 160'(upd_ready_o[i]), 160'(reset && !busy));
    check_val({p, "lk_ready"},  160'(lk_ready_o[i]),  160'(reset && !busy && !upd_valid[i]));
    check_val({p, "index_tag_enable"}, 160'(ite_o[i]), 160'(busy && off == 0));
    check_val({p, "bank_rd_en"}, 160'(rd_o[i]), 160'(busy && kind_m[i] == 1 && off == 1));
    check_val({p, "bank_wr_en"}, 160'(wr_o[i]), 160'(busy && kind_m[i] == 2 && off == 1));
    check_val({p, "lk_done"}, 160'(lk_done_o[i]),
              160'(busy && kind_m[i] == 1 && off == 1 + int'(lat_m[i])));
    check_val({p, "gen_pc_addr"}, 160'(gpc_o[i]), 160'(pc_m[i]));
    check_val({p, "gen_ghist"}, 160'(gh_o[i]), 160'(gh_m[i]));
    check_val({p, "lookup_cnt"}, (i == 0) ? 160'(lkc0) : 160'(lkc1), 160'(lkc_m[i]));
    check_val({p, "mispred_cnt"}, (i == 0) ? 160'(mpc0) : 160'(mpc1), 160'(mpc_m[i]));
  endtask

  // one clock cycle: check mid-cycle, predict the coming edge, return at posedge+1
  task automatic step();
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      bit busy = busy_m(i);
      check_outputs(i);
      lk_acc[i]  = 0;
      upd_acc[i] = 0;
      if (busy && kind_m[i] == 2 && cyc == s_m[i] + 1)
        gh_m[i] = {gh_m[i][GL-2:0], tk_m[i]};
      if (reset && !busy) begin
        if (upd_valid[i]) begin
          upd_acc[i] = 1; kind_m[i] = 2; s_m[i] = cyc + 1; len_m[i] = 2;
          pc_m[i] = upd_pc[i]; tk_m[i] = upd_taken[i];
          if (upd_mispred[i] && mpc_m[i] < cmax_m[i]) mpc_m[i]++;
        end else if (lk_valid[i]) begin
          lk_acc[i] = 1; kind_m[i] = 1; s_m[i] = cyc + 1; len_m[i] = int'(lat_m[i]) + 2;
          pc_m[i] = lk_pc[i];
          if (lkc_m[i] < cmax_m[i]) lkc_m[i]++;
        end
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 2; i++) begin
      if (lk_acc[i])  lk_valid[i]  = 1'b0;
      if (upd_acc[i]) upd_valid[i] = 1'b0;
      if (!upd_valid[i] && $urandom_range(0, 3) == 0) begin
        upd_valid[i]   = 1'b1;
        upd_pc[i]      = $urandom;
        upd_taken[i]   = 1'($urandom_range(0, 1));
        upd_mispred[i] = 1'($urandom_range(0, 1));
      end
      if (!lk_valid[i] && $urandom_range(0, 1) == 0) begin
        lk_valid[i] = 1'b1;
        lk_pc[i]    = $urandom;
      end
    end
  endtask

  task automatic run_until_idle();
    int k = 0;
    while ((busy_m(0) || busy_m(1)) && k < 30) begin
      step();
      k++;
    end
    check_val("idle_timeout", 160'(busy_m(0) || busy_m(1)), 160'(0));
  endtask

  task automatic drive_update(logic t);
    bit got[2] = '{0, 0};
    int k = 0;
    for (int i = 0; i < 2; i++) begin
      upd_valid[i] = 1'b1; upd_taken[i] = t; upd_mispred[i] = 1'b1; upd_pc[i] = $urandom;
    end
    while (!(got[0] && got[1]) && k < 30) begin
      step();
      for (int i = 0; i < 2; i++)
        if (upd_acc[i]) begin got[i] = 1; upd_valid[i] = 1'b0; end
      k++;
    end
    check_val("upd_accept_timeout", 160'(got[0] && got[1]), 160'(1));
    run_until_idle();
  endtask

  task automatic do_async_reset();
    reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lk_valid[i] = 1'b1; lk_pc[i] = 32'h1234;
      upd_valid[i] = 1'b0; upd_pc[i] = '0; upd_taken[i] = 1'b0; upd_mispred[i] = 1'b0;
    end
    // held in reset with a pending lookup: everything reads 0
    repeat (3) step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 2; i++) if (lk_acc[i]) lk_valid[i] = 1'b0;
    run_until_idle();
    for (int i = 0; i < 2; i++) lk_valid[i] = 1'b0;

    drive_update(1'b1);
    drive_update(1'b0);
    drive_update(1'b1);
    check_val("u0.ghist_101", 160'(gh_o[0][2:0]), 160'(3'b101));
    check_val("u1.ghist_101", 160'(gh_o[1][2:0]), 160'(3'b101));

    // simultaneous requests, then random traffic with one async reset in the middle
    for (int i = 0; i < 2; i++) begin
      lk_valid[i] = 1'b1; lk_pc[i] = $urandom;
      upd_valid[i] = 1'b1; upd_pc[i] = $urandom; upd_taken[i] = 1'b1; upd_mispred[i] = 1'b0;
    end
    for (int n = 0; n < 800; n++) begin
      step();
      if (n == 400) do_async_reset();
      if (n == 403) reset = 1'b1;
      randomize_inputs();
    end

    for (int i = 0; i < 2; i++) begin lk_valid[i] = 1'b0; upd_valid[i] = 1'b0; end
    run_until_idle();

    // reset while the BANK_LAT=4 instance sits in WAIT: no lk_done afterwards
    for (int i = 0; i < 2; i++) begin lk_valid[i] = 1'b1; lk_pc[i] = 32'h1234; end
    begin
      int k = 0;
      while (!(kind_m[1] == 1 && cyc == s_m[1] + 2) && k < 20) begin
        step();
        for (int i = 0; i < 2; i++) if (lk_acc[i]) lk_valid[i] = 1'b0;
        k++;
      end
      check_val("wait_reach_timeout", 160'(kind_m[1] == 1 && cyc == s_m[1] + 2), 160'(1));
    end
    do_async_reset();
    repeat (2) step();
    reset = 1'b1;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
